pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_seq_pkg.sv | 25 ++
 rtl/pc_sequencer_ras.sv | 80 ++++++++
 rtl/pc_sequencer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// ---------------------------------------------------------------------------
// pc_seq_pkg : shared constants and next-PC source enum for pc_sequencer
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pc_seq_pkg;

  localparam int unsigned XLEN_DEF      = 32;
  localparam int unsigned RESET_VEC_DEF = 0;
  localparam int unsigned INC_DEF       = 4;
  localparam int unsigned RAS_DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    SRC_SEQ    = 3'd0,
    SRC_BRANCH = 3'd1,
    SRC_JUMP   = 3'd2,
    SRC_RET    = 3'd3,
    SRC_FLUSH  = 3'd4,
    SRC_HOLD   = 3'd5
  } pc_src_e;

endpackage

`default_nettype wire

// File: rtl/pc_sequencer_ras.sv
// ---------------------------------------------------------------------------
// pc_ras   : circular return-address stack; oldest entry is overwritten when full
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pc_ras #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         swap,
  input  logic [XLEN-1:0]              wdata,
  output logic [XLEN-1:0]              top,
  output logic [$clog2(RAS_DEPTH):0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

  logic [XLEN-1:0]  mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d, top_idx, widx;
  logic [CNT_W-1:0] count_q, count_d;
  logic             we;

  // ptr_q always names the next free slot; the top lives one below it
  assign top_idx = ptr_q - PTR_W'(1);

  always_comb begin
    ptr_d     = ptr_q;
    count_d   = count_q;
    we        = 1'b0;
    widx      = ptr_q;
    overflow  = 1'b0;
    underflow = 1'b0;
    if (swap && (count_q != '0)) begin
      we   = 1'b1;
      widx = top_idx;
    end else if (push) begin
      we    = 1'b1;
      widx  = ptr_q;
      ptr_d = ptr_q + PTR_W'(1);
      if (count_q == FULL) overflow = 1'b1;
      else                 count_d  = count_q + CNT_W'(1);
    end else if (pop) begin
      if (count_q == '0) begin
        underflow = 1'b1;
      end else begin
        ptr_d   = top_idx;
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[widx] <= wdata;
  end

  assign top   = (count_q == '0) ? '0 : mem_q[top_idx];
  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer : PC register, prioritised next-PC mux and sticky RAS flags
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned     XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEF),
  parameter int unsigned     INC       = INC_DEF,
  parameter int unsigned     RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall,
  input  logic                        flush,
  input  logic [XLEN-1:0]             flush_target,
  input  logic                        branch_taken,
  input  logic [XLEN-1:0]             branch_target,
  input  logic                        jump,
  input  logic                        call,
  input  logic [XLEN-1:0]             jump_target,
  input  logic                        ret,
  output logic [XLEN-1:0]             pc,
  output logic [XLEN-1:0]             pc_next,
  output logic [XLEN-1:0]             ras_top,
  output logic [$clog2(RAS_DEPTH):0]  ras_count,
  output logic                        ras_overflow,
  output logic                        ras_underflow
);

  localparam logic [XLEN-1:0] INC_V      = XLEN'(INC);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(INC_V - XLEN'(1));

  logic [XLEN-1:0] pc_q, pc_d, seq_pc;
  logic            ras_overflow_q, ras_overflow_d;
  logic            ras_underflow_q, ras_underflow_d;
  logic            ras_push, ras_pop, ras_swap;
  logic            ovf_pulse, unf_pulse;
  pc_src_e         src;

  assign seq_pc = pc_q + INC_V;

  always_comb begin
    src      = SRC_SEQ;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    ras_swap = 1'b0;
    if (flush) begin
      src = SRC_FLUSH;
    end else if (stall) begin
      src = SRC_HOLD;
    end else if (ret) begin
      if (ras_count != '0) begin
        src      = SRC_RET;
        ras_swap = call;
        ras_pop  = !call;
      end else if (call) begin
        // coroutine swap on an empty stack degenerates to a plain call
        src      = SRC_JUMP;
        ras_push = 1'b1;
      end else begin
        // empty pop: stack reports underflow, PC falls through sequentially
        src     = SRC_SEQ;
        ras_pop = 1'b1;
      end
    end else if (call) begin
      src      = SRC_JUMP;
      ras_push = 1'b1;
    end else if (jump) begin
      src = SRC_JUMP;
    end else if (branch_taken) begin
      src = SRC_BRANCH;
    end
  end

  always_comb begin
    pc_d = seq_pc;
    unique case (src)
      SRC_FLUSH:  pc_d = flush_target  & ALIGN_MASK;
      SRC_HOLD:   pc_d = pc_q;
      SRC_RET:    pc_d = ras_top       & ALIGN_MASK;
      SRC_JUMP:   pc_d = jump_target   & ALIGN_MASK;
      SRC_BRANCH: pc_d = branch_target & ALIGN_MASK;
      default:    pc_d = seq_pc;
    endcase
  end

  assign ras_overflow_d  = ras_overflow_q  | ovf_pulse;
  assign ras_underflow_d = ras_underflow_q | unf_pulse;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q            <= RESET_VEC;
      ras_overflow_q  <= 1'b0;
      ras_underflow_q <= 1'b0;
    end else begin
      pc_q            <= pc_d;
      ras_overflow_q  <= ras_overflow_d;
      ras_underflow_q <= ras_underflow_d;
    end
  end

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .swap      (ras_swap),
    .wdata     (seq_pc),
    .top       (ras_top),
    .count     (ras_count),
    .overflow  (ovf_pulse),
    .underflow (unf_pulse)
  );

  assign pc            = pc_q;
  assign pc_next       = pc_d;
  assign ras_overflow  = ras_overflow_q;
  assign ras_underflow = ras_underflow_q;

endmodule

`default_nettype wire
